// File: rtl/aes_bram_port_arbiter.sv
// Round-robin arbiter that shares one BRAM start/complete port between two AES
// engine controllers, with a completion timeout so a hung BRAM cannot stall both.
//
// state  | meaning
// S_IDLE | no transaction; pick a pending requester and launch its strobe
// S_WAIT | strobe, address and data held until bram_complete or timeout
// S_DONE | done (and err on timeout) pulse for the served requester
module aes_bram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              aes_clk,
  input  logic              aes_rst_n,
  input  logic [1:0]        req_rd,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bram_start_read,
  output logic              bram_start_write,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_write_data,
  input  logic              bram_complete,
  input  logic [DATA_W-1:0] bram_read_data
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              start_rd_q;
  logic              start_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        pend;
  logic              gnt_d;
  logic              sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pend = req_rd | req_wr;

  // When both are pending, the one not served last wins.
  always_comb begin
    gnt_d = 1'b0;
    case (pend)
      2'b01:   gnt_d = 1'b0;
      2'b10:   gnt_d = 1'b1;
      2'b11:   gnt_d = ~last_grant_q;
      default: gnt_d = 1'b0;
    endcase
  end

  assign sel_rd    = gnt_d ? req_rd[1]  : req_rd[0];
  assign sel_addr  = gnt_d ? req_addr1  : req_addr0;
  assign sel_wdata = gnt_d ? req_wdata1 : req_wdata0;

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rd_data_q    <= '0;
      start_rd_q   <= 1'b0;
      start_wr_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (|pend) begin
            gnt_q      <= gnt_d;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            // A read request takes precedence over a simultaneous write.
            start_rd_q <= sel_rd;
            start_wr_q <= ~sel_rd;
            cnt_q      <= '0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bram_complete) begin
            start_rd_q    <= 1'b0;
            start_wr_q    <= 1'b0;
            if (start_rd_q) rd_data_q <= bram_read_data;
            done_q[gnt_q] <= 1'b1;
            last_grant_q  <= gnt_q;
            state_q       <= S_DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            start_rd_q    <= 1'b0;
            start_wr_q    <= 1'b0;
            rd_data_q     <= '0;
            done_q[gnt_q] <= 1'b1;
            err_q[gnt_q]  <= 1'b1;
            last_grant_q  <= gnt_q;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done             = done_q;
  assign err              = err_q;
  assign rd_data          = rd_data_q;
  assign busy             = (state_q != S_IDLE);
  assign bram_start_read  = start_rd_q;
  assign bram_start_write = start_wr_q;
  assign bram_addr        = addr_q;
  assign bram_write_data  = wdata_q;

endmodule

// File: tb/tb_aes_bram_port_arbiter.sv
// Directed bench for aes_bram_port_arbiter with hand-computed expectations;
// inputs change and outputs are sampled 1 ns after the rising edge.
module tb_aes_bram_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              aes_clk;
  logic              aes_rst_n;
  logic [1:0]        req_rd;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        done;
  logic [1:0]        err;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              bram_start_read;
  logic              bram_start_write;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_write_data;
  logic              bram_complete;
  logic [DATA_W-1:0] bram_read_data;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;
  int strobe_cycles;

  aes_bram_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(16)
  ) dut (
    .aes_clk         (aes_clk),
    .aes_rst_n       (aes_rst_n),
    .req_rd          (req_rd),
    .req_wr          (req_wr),
    .req_addr0       (req_addr0),
    .req_addr1       (req_addr1),
    .req_wdata0      (req_wdata0),
    .req_wdata1      (req_wdata1),
    .done            (done),
    .err             (err),
    .rd_data         (rd_data),
    .busy            (busy),
    .bram_start_read (bram_start_read),
    .bram_start_write(bram_start_write),
    .bram_addr       (bram_addr),
    .bram_write_data (bram_write_data),
    .bram_complete   (bram_complete),
    .bram_read_data  (bram_read_data)
  );

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  always @(negedge aes_clk) if (bram_start_read && bram_start_write) both_hi++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    aes_rst_n = 1'b0; req_rd = '0; req_wr = '0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    bram_complete = 1'b0; bram_read_data = '0;
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {bram_start_read, bram_start_write}, 0);
    chk("rst_addr", bram_addr, 0);
    aes_rst_n = 1'b1;
    tick();

    // single read, 4-cycle BRAM latency
    req_rd = 2'b01; req_addr0 = 32'h100;
    tick();
    chk("rd_strobe", bram_start_read, 1);
    chk("rd_no_wr", bram_start_write, 0);
    chk("rd_addr", bram_addr, 32'h100);
    chk("rd_busy", busy, 1);
    tick(); tick(); tick();
    chk("rd_held", bram_start_read, 1);
    chk("rd_no_done_yet", done, 0);
    bram_complete = 1'b1; bram_read_data = 32'hDEADBEEF;
    tick();
    chk("rd_done", done, 2'b01);
    chk("rd_data", rd_data, 32'hDEADBEEF);
    chk("rd_err", err, 0);
    chk("rd_strobe_drop", bram_start_read, 0);
    bram_complete = 1'b0; req_rd = '0;
    tick();
    chk("rd_done_clear", done, 0);
    chk("rd_idle", busy, 0);

    // single write by requester 1
    req_wr = 2'b10; req_addr1 = 32'h200; req_wdata1 = 32'h12345678;
    tick();
    chk("wr_strobe", {bram_start_read, bram_start_write}, 2'b01);
    chk("wr_addr", bram_addr, 32'h200);
    chk("wr_data", bram_write_data, 32'h12345678);
    tick(); tick();
    chk("wr_held", bram_start_write, 1);
    bram_complete = 1'b1; bram_read_data = 32'hBAD0BAD0;
    tick();
    chk("wr_done", done, 2'b10);
    chk("wr_rd_data_kept", rd_data, 32'hDEADBEEF);
    chk("wr_strobe_drop", bram_start_write, 0);
    bram_complete = 1'b0; req_wr = '0;
    tick();

    // contention: both hold reads, expect 0,1,0,1
    req_rd = 2'b11; req_addr0 = 32'h300; req_addr1 = 32'h304;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("cont_addr", bram_addr, (t % 2 == 1) ? 32'h304 : 32'h300);
      chk("cont_strobe", bram_start_read, 1);
      bram_complete = 1'b1; bram_read_data = 32'hC0DE0000 + t;
      tick();
      chk("cont_done", done, (t % 2 == 1) ? 2'b10 : 2'b01);
      chk("cont_data", rd_data, 32'hC0DE0000 + t);
      bram_complete = 1'b0;
      tick();
    end
    req_rd = '0;
    tick();

    // timeout on requester 0 while requester 1 also waits
    req_rd = 2'b11; req_addr0 = 32'h400; req_addr1 = 32'h404;
    strobe_cycles = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bram_start_read) strobe_cycles++;
    end
    chk("to_strobe_cycles", strobe_cycles, 16);
    chk("to_addr", bram_addr, 32'h400);
    tick();
    chk("to_done", done, 2'b01);
    chk("to_err", err, 2'b01);
    chk("to_rd_data", rd_data, 0);
    chk("to_strobe_drop", bram_start_read, 0);
    req_rd = 2'b10;
    tick();
    chk("to_err_clear", err, 0);
    tick();
    chk("to_next_addr", bram_addr, 32'h404);
    bram_complete = 1'b1; bram_read_data = 32'h5A5A5A5A;
    tick();
    chk("to_next_done", done, 2'b10);
    chk("to_next_err", err, 0);
    chk("to_next_data", rd_data, 32'h5A5A5A5A);
    bram_complete = 1'b0; req_rd = '0;
    tick();

    // read and write together on requester 0: read only
    req_rd = 2'b01; req_wr = 2'b01; req_addr0 = 32'h700; req_wdata0 = 32'h11112222;
    tick();
    chk("conf_strobes", {bram_start_read, bram_start_write}, 2'b10);
    bram_complete = 1'b1; bram_read_data = 32'h77778888;
    tick();
    chk("conf_done", done, 2'b01);
    chk("conf_data", rd_data, 32'h77778888);
    bram_complete = 1'b0; req_rd = '0; req_wr = '0;
    tick();
    tick();
    chk("conf_single_done", done, 0);
    chk("conf_idle", {busy, bram_start_write}, 0);

    // reset in WAIT of a requester 1 write; last grant was 0 beforehand
    req_wr = 2'b10; req_addr1 = 32'h500; req_wdata1 = 32'hCAFEF00D;
    tick();
    chk("rst_wr_strobe", bram_start_write, 1);
    tick();
    aes_rst_n = 1'b0;
    #1;
    chk("rst_mid_strobe", bram_start_write, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    req_wr = '0;
    aes_rst_n = 1'b1;
    tick();
    chk("rst_post_done", done, 0);
    req_rd = 2'b11; req_addr0 = 32'h800; req_addr1 = 32'h900;
    tick();
    chk("rst_prio_addr", bram_addr, 32'h800);
    bram_complete = 1'b1; bram_read_data = 32'h00008888;
    tick();
    chk("rst_prio_done", done, 2'b01);
    bram_complete = 1'b0; req_rd = 2'b10;
    tick(); tick();
    chk("rst_r1_addr", bram_addr, 32'h900);
    chk("rst_r1_strobe", bram_start_read, 1);
    bram_complete = 1'b1; bram_read_data = 32'h00009999;
    tick();
    chk("rst_r1_done", done, 2'b10);
    chk("rst_r1_data", rd_data, 32'h00009999);
    bram_complete = 1'b0; req_rd = '0;
    tick();

    // stray complete in IDLE is ignored
    bram_complete = 1'b1; bram_read_data = 32'hFFFFFFFF;
    tick();
    chk("idle_cpl_done", done, 0);
    chk("idle_cpl_data", rd_data, 32'h00009999);
    bram_complete = 1'b0;
    tick();

    chk("both_strobes", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
